// File: rtl/bram_slave_port.sv
// Serial bus slave: deserialises mode/address/write-data, drives BRAM writes and timed reads.
// Latency: write strobe the cycle after the last data bit; read data serialised RD_LAT edges after the last address bit.
// Backpressure: s_ready only in IDLE (new requests elsewhere are dropped); m_ready=0 holds the current read bit.
module bram_slave_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_wdata,
  output logic              s_ready,
  output logic              s_rvalid,
  output logic              s_rdata,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_wren,
  output logic              bram_rden,
  input  logic [DATA_W-1:0] bram_q
);

  // The counter is shared by the address, data and read-latency phases,
  // so it must be wide enough for the longest of the three.
  localparam int MAX_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_MAX = (MAX_W > RD_LAT) ? MAX_W : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RREQ  = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              mode;
  logic [DATA_W-1:0] rd_sh;

  // Request deserialisation, BRAM access sequencing and read-data serialisation.
  // Address and write data shift in from the top so the first (LSB) bit
  // lands in bit 0 once the field is complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode       <= 1'b0;
      rd_sh      <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            mode  <= m_wdata;
            cnt   <= '0;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_valid) begin
            bram_addr <= {m_wdata, bram_addr[ADDR_W-1:1]};
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= mode ? ST_WDATA : ST_RREQ;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_WDATA: begin
          if (m_valid) begin
            bram_wdata <= {m_wdata, bram_wdata[DATA_W-1:1]};
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= ST_WRITE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        ST_RREQ: begin
          // Read data is only trusted on the last latency edge.
          if (cnt == LAT_LAST) begin
            rd_sh <= bram_q;
            cnt   <= '0;
            state <= ST_RDATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RDATA: begin
          if (m_ready) begin
            rd_sh <= rd_sh >> 1;
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Handshake and BRAM strobes decode straight from state; WRITE and RREQ are
  // exclusive states, so wren and rden can never overlap.
  always_comb begin
    s_ready   = (state == ST_IDLE);
    s_rvalid  = (state == ST_RDATA);
    s_rdata   = (state == ST_RDATA) & rd_sh[0];
    bram_wren = (state == ST_WRITE);
    bram_rden = (state == ST_RREQ);
  end

endmodule

// File: tb/tb_bram_slave_port.sv
// Bench for bram_slave_port: random and directed serial requests against a BRAM model and a reference memory.
// Latency: checks write strobe timing, RD_LAT read timing and serial readout order.
// Backpressure: exercises m_valid stalls, m_ready holds and ignored requests while busy.
module tb_bram_slave_port;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m_valid = 1'b0;
  logic              m_wdata = 1'b0;
  logic              m_ready = 1'b0;
  logic              s_ready;
  logic              s_rvalid;
  logic              s_rdata;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              bram_wren;
  logic              bram_rden;
  logic [DATA_W-1:0] bram_q;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wren_cycles = 0;
  int overlap = 0;
  int exp_writes = 0;

  // Reference contents: what every address should hold after the writes issued so far.
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  // Environment BRAM: one registered stage so q is valid RD_LAT(=2) clocks after rden.
  logic [DATA_W-1:0] bmem [0:DEPTH-1];
  logic [DATA_W-1:0] q_reg = '0;

  bram_slave_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_wdata   (m_wdata),
    .s_ready   (s_ready),
    .s_rvalid  (s_rvalid),
    .s_rdata   (s_rdata),
    .m_ready   (m_ready),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .bram_wren (bram_wren),
    .bram_rden (bram_rden),
    .bram_q    (bram_q)
  );

  always #5 clk = ~clk;

  // BRAM behaviour seen by the slave.
  always @(posedge clk) begin
    if (bram_wren) bmem[bram_addr] <= bram_wdata;
    if (bram_rden) q_reg <= bmem[bram_addr];
  end
  assign bram_q = q_reg;

  // Count strobe cycles so early, stretched or spurious writes show up at the end.
  always @(negedge clk) begin
    if (reset) begin
      if (bram_wren) wren_cycles++;
      if (bram_wren && bram_rden) overlap++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_ready"}, s_ready, 1);
    chk({tag, "_rvalid"}, s_rvalid, 0);
    chk({tag, "_rdata"}, s_rdata, 0);
    chk({tag, "_wren"}, bram_wren, 0);
    chk({tag, "_rden"}, bram_rden, 0);
    chk({tag, "_addr"}, bram_addr, 0);
    chk({tag, "_wdata"}, bram_wdata, 0);
  endtask

  // Drive the first nsend bits of the request stream (mode, addr LSB-first, data LSB-first).
  // Called and returns at a negedge; after stream bit stall_idx, m_valid drops for stall_len cycles.
  task automatic send_bits(input logic mode, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int nsend,
                           input int stall_idx, input int stall_len);
    logic [ADDR_W+DATA_W:0] stream;
    stream = {d, a, mode};
    for (int i = 0; i < nsend; i++) begin
      m_valid = 1'b1;
      m_wdata = stream[i];
      @(negedge clk);
      if (i == stall_idx) begin
        m_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          m_wdata = 1'($urandom);
          @(negedge clk);
          chk("stall_busy", s_ready, 0);
          chk("stall_no_wren", bram_wren, 0);
        end
      end
    end
    m_valid = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int stall_idx, input int stall_len);
    send_bits(1'b1, a, d, 1 + ADDR_W + DATA_W, stall_idx, stall_len);
    chk("wr_wren", bram_wren, 1);
    chk("wr_rden", bram_rden, 0);
    chk("wr_addr", bram_addr, a);
    chk("wr_wdata", bram_wdata, d);
    chk("wr_busy", s_ready, 0);
    ref_mem[a] = d;
    exp_writes++;
    @(negedge clk);
    chk("wr_wren_off", bram_wren, 0);
    chk("wr_ready", s_ready, 1);
  endtask

  // bp_bit>=0: hold m_ready low for bp_len cycles while that bit is offered;
  // bp_bit<0: random m_ready. junk: toggle m_valid/m_wdata during readout.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int bp_bit, input int bp_len,
                         input bit junk);
    logic [DATA_W-1:0] got;
    logic b;
    logic mr;
    int nb;
    int hold;
    int guard;
    send_bits(1'b0, a, '0, 1 + ADDR_W, -1, 0);
    for (int k = 0; k < RD_LAT; k++) begin
      chk("rd_rden", bram_rden, 1);
      chk("rd_addr", bram_addr, a);
      chk("rd_no_rvalid", s_rvalid, 0);
      @(negedge clk);
    end
    chk("rd_rden_off", bram_rden, 0);
    chk("rd_rvalid", s_rvalid, 1);
    got = '0;
    nb = 0;
    hold = 0;
    guard = 0;
    while (nb < DATA_W && guard < 200 && s_rvalid) begin
      guard++;
      b = s_rdata;
      if (nb == bp_bit && hold < bp_len) begin
        mr = 1'b0;
        hold++;
      end else if (bp_bit < 0) begin
        mr = (($urandom % 3) != 0);
      end else begin
        mr = 1'b1;
      end
      m_ready = mr;
      if (junk) begin
        m_valid = 1'($urandom);
        m_wdata = 1'($urandom);
      end
      @(negedge clk);
      if (mr) begin
        got[nb] = b;
        nb++;
      end else begin
        chk("rd_hold", s_rdata, b);
      end
    end
    m_ready = 1'b0;
    m_valid = 1'b0;
    chk("rd_bits", nb, DATA_W);
    chk("rd_data", got, ref_mem[a]);
    chk("rd_end_rvalid", s_rvalid, 0);
    chk("rd_end_ready", s_ready, 1);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      bmem[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    // Basic write then read-back of 0x05 at address 15
    do_write(12'd15, 8'h05, -1, 0);
    do_read(12'd15, -1, 0, 1'b0);

    // m_valid stall after address bit 4 (stream index 5)
    do_write(12'h2C7, 8'h3C, 5, 3);
    do_read(12'h2C7, -1, 0, 1'b0);

    // Backpressure mid-readout of 0xA5
    do_write(12'h400, 8'hA5, -1, 0);
    do_read(12'h400, 3, 4, 1'b0);

    // Reset while in WDATA: no write may happen, outputs return to reset values
    send_bits(1'b1, 12'h123, 8'h5A, 1 + ADDR_W + 3, -1, 0);
    chk("wdata_busy", s_ready, 0);
    reset = 1'b0;
    #1;
    chk_idle_reset("rst_wdata");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_read(12'h123, -1, 0, 1'b0);

    // Reset while in RDATA after three bits accepted
    send_bits(1'b0, 12'd15, '0, 1 + ADDR_W, -1, 0);
    repeat (RD_LAT) @(negedge clk);
    chk("rdata_rvalid", s_rvalid, 1);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    m_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk_idle_reset("rst_rdata");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_read(12'd15, -1, 0, 1'b0);

    // Address/data extremes, with junk m_valid during readout
    do_write(12'hFFF, 8'hFF, -1, 0);
    do_write(12'h000, 8'h00, -1, 0);
    do_read(12'hFFF, -1, 0, 1'b1);
    do_read(12'h000, -1, 0, 1'b1);

    // Randomised mix
    for (int t = 0; t < 40; t++) begin
      ra = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd = DATA_W'($urandom);
      if (($urandom % 2) == 0) begin
        if (($urandom % 4) == 0)
          do_write(ra, rd, int'($urandom_range(0, ADDR_W + DATA_W - 1)), int'($urandom_range(1, 4)));
        else
          do_write(ra, rd, -1, 0);
        do_read(ra, -1, 0, 1'($urandom));
      end else begin
        do_read(ra, -1, 0, 1'($urandom));
      end
    end

    chk("wren_cycles", wren_cycles, exp_writes);
    chk("wren_rden_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
